// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR addresses, op encodings, FSM states and bit indices (CSR_VECTORED_EN selects vectored mtvec support)
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;
  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;
  localparam int MTIP_BIT = 7;
  typedef enum logic [1:0] {IDLE, ACCESS, TRAP, MRET} csr_state_e;
endpackage

// File: rtl/csr_regfile.sv
// csr_regfile: M-mode CSR storage, read mux, write masking, illegal decode; ports addr/wdata/we -> rdata/illegal, trap/mret update ports (CSR_VECTORED_EN makes mtvec[1:0] writable)
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        illegal,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  input  logic        irq_timer,
  output logic        mstatus_mie,
  output logic        mie_mtie,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);
`ifdef CSR_VECTORED_EN
  localparam logic [31:0] TVEC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] TVEC_MASK = 32'hFFFF_FFFC;
`endif
  logic        mstatus_mpie;
  logic [31:0] mscratch, mcause;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec        <= MTVEC_RESET & TVEC_MASK;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
    end else if (trap) begin
      mepc         <= trap_pc & ~32'h3;
      mcause       <= MCAUSE_MTI;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (we) begin
      case (addr)
        CSR_MSTATUS: begin
          mstatus_mie  <= wdata[MIE_BIT];
          mstatus_mpie <= wdata[MPIE_BIT];
        end
        CSR_MIE:      mie_mtie <= wdata[MTIE_BIT];
        CSR_MTVEC:    mtvec    <= wdata & TVEC_MASK;
        CSR_MSCRATCH: mscratch <= wdata;
        CSR_MEPC:     mepc     <= wdata & ~32'h3;
        CSR_MCAUSE:   mcause   <= wdata;
        default: ;
      endcase
    end
  end
  always_comb begin
    rdata   = '0;
    illegal = 1'b0;
    case (addr)
      CSR_MSTATUS: begin
        rdata[MIE_BIT]  = mstatus_mie;
        rdata[MPIE_BIT] = mstatus_mpie;
      end
      CSR_MIE:      rdata[MTIE_BIT] = mie_mtie;
      CSR_MTVEC:    rdata = mtvec;
      CSR_MSCRATCH: rdata = mscratch;
      CSR_MEPC:     rdata = mepc;
      CSR_MCAUSE:   rdata = mcause;
      CSR_MIP:      rdata[MTIP_BIT] = irq_timer;
      default:      illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/csr_seq.sv
// csr_seq: M-mode CSR sequencer (2-cycle RMW, timer trap entry, mret) with stall and PC redirect; ports csr_* request/response, mret_i, pc_i, irq_timer_i, redirect_* (CSR_VECTORED_EN enables vectored interrupt target)
module csr_seq
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        csr_req_i,
  input  logic [2:0]  csr_funct3_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_rs1_data_i,
  input  logic [4:0]  csr_zimm_i,
  input  logic        mret_i,
  input  logic [31:0] pc_i,
  input  logic        irq_timer_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_stall_o,
  output logic        csr_done_o,
  output logic        illegal_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);
  csr_state_e  state, next;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] src_q, pc_q, rdata, wdata, mtvec, mepc, tvec_base, trap_target;
  logic        nowr_q, illegal, mstatus_mie, mie_mtie, irq_pending, we;
  assign irq_pending = mstatus_mie & mie_mtie & irq_timer_i;
  always_comb begin
    next = state == IDLE ? (irq_pending ? TRAP : mret_i ? MRET : csr_req_i ? ACCESS : IDLE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= next;
  end
  // Operands are captured every IDLE cycle; the last one before leaving IDLE is what ACCESS/TRAP use.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      op_q   <= csr_funct3_i[1:0];
      addr_q <= csr_addr_i;
      src_q  <= csr_funct3_i[2] ? {27'b0, csr_zimm_i} : csr_rs1_data_i;
      nowr_q <= csr_funct3_i[1] & ~|csr_zimm_i;
      pc_q   <= pc_i;
    end
  end
  assign wdata = op_q == OP_RW ? src_q : op_q == OP_RS ? rdata | src_q : rdata & ~src_q;
  assign we    = state == ACCESS & ~illegal & ~nowr_q;
  csr_regfile #(.MTVEC_RESET(MTVEC_RESET)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr_q),
    .wdata      (wdata),
    .we         (we),
    .rdata      (rdata),
    .illegal    (illegal),
    .trap       (state == TRAP),
    .trap_pc    (pc_q),
    .mret       (state == MRET),
    .irq_timer  (irq_timer_i),
    .mstatus_mie(mstatus_mie),
    .mie_mtie   (mie_mtie),
    .mtvec      (mtvec),
    .mepc       (mepc)
  );
  assign tvec_base = mtvec & ~32'h3;
`ifdef CSR_VECTORED_EN
  assign trap_target = tvec_base + (mtvec[1:0] == 2'b01 ? 32'd28 : 32'd0);
`else
  assign trap_target = tvec_base;
`endif
  assign csr_stall_o   = state != IDLE | (rst_n & (irq_pending | mret_i | csr_req_i));
  assign csr_done_o    = state == ACCESS | state == MRET;
  assign csr_rdata_o   = state == ACCESS ? rdata : '0;
  assign illegal_o     = state == ACCESS & illegal;
  assign redirect_o    = state == TRAP | state == MRET;
  assign redirect_pc_o = state == TRAP ? trap_target : state == MRET ? mepc : '0;
endmodule

// File: tb/tb_csr_seq.sv
// tb_csr_seq: directed self-checking bench for csr_seq
module tb_csr_seq;
  logic        clk = 0, rst_n = 0, csr_req_i = 0, mret_i = 0, irq_timer_i = 0;
  logic [2:0]  csr_funct3_i = 0;
  logic [11:0] csr_addr_i = 0;
  logic [31:0] csr_rs1_data_i = 0, pc_i = 0;
  logic [4:0]  csr_zimm_i = 0;
  logic [31:0] csr_rdata_o, redirect_pc_o;
  logic        csr_stall_o, csr_done_o, illegal_o, redirect_o;
  int n_checks = 0, n_errors = 0;
  logic [31:0] v;
  logic        ill;
`ifdef CSR_VECTORED_EN
  localparam logic [31:0] EXP_TVEC = 32'h101, EXP_TGT = 32'h11C;
`else
  localparam logic [31:0] EXP_TVEC = 32'h100, EXP_TGT = 32'h100;
`endif
  csr_seq dut (
    .clk(clk), .rst_n(rst_n), .csr_req_i(csr_req_i), .csr_funct3_i(csr_funct3_i),
    .csr_addr_i(csr_addr_i), .csr_rs1_data_i(csr_rs1_data_i), .csr_zimm_i(csr_zimm_i),
    .mret_i(mret_i), .pc_i(pc_i), .irq_timer_i(irq_timer_i), .csr_rdata_o(csr_rdata_o),
    .csr_stall_o(csr_stall_o), .csr_done_o(csr_done_o), .illegal_o(illegal_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                        input logic [4:0] z, output logic [31:0] rd, output logic il);
    int n = 0;
    @(negedge clk);
    csr_req_i = 1; csr_funct3_i = f3; csr_addr_i = a; csr_rs1_data_i = rs1; csr_zimm_i = z;
    #1 check("stall_accept", csr_stall_o, 1);
    do begin
      @(posedge clk); #1; n++;
    end while (!csr_done_o && n < 4);
    check("latency", n, 1);
    rd = csr_rdata_o;
    il = illegal_o;
    csr_req_i = 0;
    @(posedge clk); #1;
    check("done_pulse", csr_done_o, 0);
  endtask
  task automatic rd_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        i;
    csr_op(3'b010, a, 32'hFFFF_FFFF, 5'd0, r, i);
    check(tag, r, exp);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", csr_done_o, 0);
    check("rst_stall", csr_stall_o, 0);
    check("rst_redirect", redirect_o, 0);
    check("rst_rdata", csr_rdata_o, 0);
    @(negedge clk) rst_n = 1;
    #1 check("idle_stall", csr_stall_o, 0);
    csr_op(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd1, v, ill);
    check("rw_mscratch_old", v, 0);
    check("rw_mscratch_ill", ill, 0);
    rd_csr("mscratch_rs0", 12'h340, 32'hDEAD_BEEF);
    rd_csr("mscratch_again", 12'h340, 32'hDEAD_BEEF);
    rd_csr("mcause_rst", 12'h342, 0);
    csr_op(3'b001, 12'h300, 32'h0000_0088, 5'd0, v, ill);
    check("mstatus_old", v, 0);
    csr_op(3'b011, 12'h300, 32'h0000_0008, 5'd1, v, ill);
    check("rc_mstatus_old", v, 32'h88);
    csr_op(3'b110, 12'h300, 32'h0, 5'd8, v, ill);
    check("rsi_mstatus_old", v, 32'h80);
    rd_csr("mstatus_rsi", 12'h300, 32'h88);
    csr_op(3'b001, 12'h300, 32'hFFFF_FFFF, 5'd1, v, ill);
    rd_csr("mstatus_mask", 12'h300, 32'h88);
    csr_op(3'b001, 12'h304, 32'hFFFF_FFFF, 5'd1, v, ill);
    rd_csr("mie_mask", 12'h304, 32'h80);
    csr_op(3'b001, 12'h305, 32'h0000_0101, 5'd1, v, ill);
    rd_csr("mtvec", 12'h305, EXP_TVEC);
    csr_op(3'b001, 12'h341, 32'h0000_002F, 5'd1, v, ill);
    rd_csr("mepc_align", 12'h341, 32'h2C);
    csr_op(3'b001, 12'h344, 32'hFFFF_FFFF, 5'd1, v, ill);
    rd_csr("mip_ro", 12'h344, 0);
    csr_op(3'b001, 12'h7C0, 32'hFFFF_FFFF, 5'd1, v, ill);
    check("illegal_pulse", ill, 1);
    check("illegal_rdata", v, 0);
    check("illegal_after", illegal_o, 0);
    // timer interrupt entry
    @(negedge clk);
    pc_i = 32'h2C; irq_timer_i = 1;
    #1 check("irq_stall", csr_stall_o, 1);
    @(posedge clk); #1;
    check("trap_redirect", redirect_o, 1);
    check("trap_target", redirect_pc_o, EXP_TGT);
    check("trap_nodone", csr_done_o, 0);
    @(posedge clk); #1;
    check("trap_pulse", redirect_o, 0);
    rd_csr("mip_irq", 12'h344, 32'h80);
    irq_timer_i = 0;
    rd_csr("trap_mepc", 12'h341, 32'h2C);
    rd_csr("trap_mcause", 12'h342, 32'h8000_0007);
    rd_csr("trap_mstatus", 12'h300, 32'h80);
    // mret
    @(negedge clk) mret_i = 1;
    @(posedge clk); #1;
    check("mret_redirect", redirect_o, 1);
    check("mret_target", redirect_pc_o, 32'h2C);
    check("mret_done", csr_done_o, 1);
    mret_i = 0;
    @(posedge clk); #1;
    check("mret_pulse", redirect_o, 0);
    rd_csr("mret_mstatus", 12'h300, 32'h88);
    // interrupt collides with a CSR write: trap wins, no write
    @(negedge clk);
    irq_timer_i = 1; pc_i = 32'h40; csr_req_i = 1; csr_funct3_i = 3'b001;
    csr_addr_i = 12'h340; csr_rs1_data_i = 32'h1234_5678; csr_zimm_i = 5'd1;
    @(posedge clk); #1;
    check("coll_redirect", redirect_o, 1);
    check("coll_target", redirect_pc_o, EXP_TGT);
    check("coll_nodone", csr_done_o, 0);
    csr_req_i = 0; irq_timer_i = 0;
    @(posedge clk); #1;
    rd_csr("coll_mscratch", 12'h340, 32'hDEAD_BEEF);
    rd_csr("coll_mepc", 12'h341, 32'h40);
    // reset in the ACCESS cycle
    @(negedge clk);
    csr_req_i = 1; csr_funct3_i = 3'b001; csr_addr_i = 12'h340; csr_rs1_data_i = 32'hAAAA_5555;
    @(posedge clk); #1;
    check("rstmid_access", csr_done_o, 1);
    rst_n = 0; csr_req_i = 0;
    @(posedge clk); #1;
    check("rstmid_done", csr_done_o, 0);
    check("rstmid_stall", csr_stall_o, 0);
    check("rstmid_redirect", redirect_o, 0);
    check("rstmid_rdata", csr_rdata_o, 0);
    check("rstmid_illegal", illegal_o, 0);
    @(negedge clk) rst_n = 1;
    rd_csr("rstmid_mscratch", 12'h340, 0);
    rd_csr("rstmid_mtvec", 12'h305, 0);
    rd_csr("rstmid_mstatus", 12'h300, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
